// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the nano_rv32i data-memory responder.
// Holds the read-FSM encodings and the byte-lane helpers.
package nano_rv32i_pkg;

    localparam logic [1:0] DM_IDLE = 2'd0;
    localparam logic [1:0] DM_WAIT = 2'd1;
    localparam logic [1:0] DM_DONE = 2'd2;

    localparam int unsigned DM_LANE_W   = 8;
    // Byte-address bits below the word index; lanes come from the masks only.
    localparam int unsigned DM_ADDR_LSB = 2;

    function automatic logic [31:0] dm_lane_mask(input logic [3:0] lanes);
        logic [31:0] m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            m[k*DM_LANE_W +: DM_LANE_W] = {DM_LANE_W{lanes[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core-to-data-memory bus: byte address, lane masks, write data and the
// responder's ready/err pulses.
interface data_mem_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  rd_i;
    logic [3:0]  we_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;

    modport master (
        output addr_i, data_i, rd_i, we_i,
        input  data_o, ready_o, err_o
    );

    modport slave (
        input  addr_i, data_i, rd_i, we_i,
        output data_o, ready_o, err_o
    );
endinterface

// File: rtl/data_mem_dmem_array.sv
// Byte-enable synchronous RAM: one lane-masked write port and one registered
// read port that only updates when re_i is set, so the word is held.
module dmem_array
    import nano_rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem[waddr_i][k*DM_LANE_W +: DM_LANE_W] <= wdata_i[k*DM_LANE_W +: DM_LANE_W];
            end
        end
    end

    // Read-before-write at a shared edge; the captured word then stays put
    // while later writes land during the latency window.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Single-port data-memory responder for nano_rv32i: lane-masked writes at any
// time, reads returned after READ_LATENCY cycles with a one-cycle ready pulse.
module data_mem
    import nano_rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    data_mem_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << DM_ADDR_LSB;
    localparam logic [3:0]  CNT_INIT = (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] widx;
    logic          rd_req;
    logic          wr_req;
    logic          accept;
    logic [3:0]    ram_we;
    logic [31:0]   rdata;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] mask_q,  mask_d;
    logic       err_q,   err_d;

    // Unsigned wrap makes addresses below BASE_ADDR fail the span compare too.
    assign offset   = bus.addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign widx     = offset[AW+1:DM_ADDR_LSB];
    assign rd_req   = |bus.rd_i;
    assign wr_req   = |bus.we_i;
    assign accept   = (state_q == DM_IDLE) && rd_req && !wr_req;
    assign ram_we   = in_range ? bus.we_i : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (widx),
        .wdata_i (bus.data_i),
        .re_i    (accept),
        .raddr_i (widx),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        err_d   = (wr_req && !in_range) || (rd_req && wr_req) || (accept && !in_range);
        case (state_q)
            DM_IDLE: begin
                if (accept) begin
                    mask_d = in_range ? bus.rd_i : 4'b0000;
                    if (READ_LATENCY == 1) begin
                        state_d = DM_DONE;
                    end else begin
                        state_d = DM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DM_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_DONE: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DM_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready_o = (state_q == DM_DONE);
    assign bus.data_o  = bus.ready_o ? (rdata & dm_lane_mask(mask_q)) : '0;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: three instances (latency 1, 4, 3) share one
// stimulus stream; each has its own expectation queue and monitor.
module tb_data_mem;

    localparam int L0 = 1;
    localparam int L1 = 4;
    localparam int L2 = 3;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    logic [31:0] a = '0, d = '0;
    logic [3:0]  r = '0, w = '0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int errc[3];
    int exp_err[3];
    bit mon_en = 1'b0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_if b0();
    data_mem_if b1();
    data_mem_if b2();

    assign b0.addr_i = a; assign b0.data_i = d; assign b0.rd_i = r; assign b0.we_i = w;
    assign b1.addr_i = a; assign b1.data_i = d; assign b1.rd_i = r; assign b1.we_i = w;
    assign b2.addr_i = a; assign b2.data_i = d; assign b2.rd_i = r; assign b2.we_i = w;

    data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(L0))
        u_dut0 (.clk_i(clk), .rst_n_i(rst0), .bus(b0));
    data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(L1))
        u_dut1 (.clk_i(clk), .rst_n_i(rst1), .bus(b1));
    data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(L2))
        u_dut2 (.clk_i(clk), .rst_n_i(rst2), .bus(b2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic rdy, input logic [31:0] dat, input logic err);
        exp_t e;
        int   n;
        if (err === 1'b1) errc[k]++;
        if (rdy === 1'b1) begin
            case (k)
                0:       n = q0.size();
                1:       n = q1.size();
                default: n = q2.size();
            endcase
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected ready: got data %h expected no ready (cycle %0d)", k, dat, cyc);
            end else begin
                case (k)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("dut%0d ready cycle", k), 32'(cyc), 32'(e.cyc));
                chk($sformatf("dut%0d read data", k), dat, e.data);
            end
        end else begin
            chk($sformatf("dut%0d idle data", k), dat, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, b0.ready_o, b0.data_o, b0.err_o);
            mon(1, b1.ready_o, b1.data_o, b1.err_o);
            mon(2, b2.ready_o, b2.data_o, b2.err_o);
        end
    end

    // Called at a negedge; the request is accepted at the following posedge.
    task automatic op(input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] rd,
                      input logic [3:0] we, input logic [31:0] ex, input bit p0, input bit p1,
                      input bit p2, input bit e, input int gap);
        int acc;
        a = ad; d = dt; r = rd; w = we;
        acc = cyc + 1;
        if (rd != 4'h0 && we == 4'h0) begin
            if (p0) q0.push_back('{ex, acc + L0 - 1});
            if (p1) q1.push_back('{ex, acc + L1 - 1});
            if (p2) q2.push_back('{ex, acc + L2 - 1});
        end
        if (e) for (int k = 0; k < 3; k++) exp_err[k]++;
        @(negedge clk);
        a = '0; d = '0; r = '0; w = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_err(input string tag);
        for (int k = 0; k < 3; k++) chk($sformatf("%s err count dut%0d", tag, k), 32'(errc[k]), 32'(exp_err[k]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin errc[k] = 0; exp_err[k] = 0; end
        repeat (2) @(negedge clk);
        chk("reset ready0", {31'b0, b0.ready_o}, 32'h0);
        chk("reset ready1", {31'b0, b1.ready_o}, 32'h0);
        chk("reset ready2", {31'b0, b2.ready_o}, 32'h0);
        chk("reset err0", {31'b0, b0.err_o}, 32'h0);
        chk("reset data1", b1.data_o, 32'h0);
        mon_en = 1'b1;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);

        op(32'h10, 32'hDEADBEEF, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 6);
        op(32'h10, 32'h0,        4'hF, 4'h0, 32'hDEADBEEF, 1, 1, 1, 0, 6);

        op(32'h20, 32'h11223344, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 2);
        op(32'h20, 32'h000000AA, 4'h0, 4'h1, 32'h0, 1, 1, 1, 0, 2);
        op(32'h20, 32'h0,        4'h3, 4'h0, 32'h000033AA, 1, 1, 1, 0, 6);

        op(32'h30, 32'h5, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 2);
        op(32'h30, 32'h0, 4'hF, 4'h0, 32'h5, 1, 1, 1, 0, 0);
        op(32'h30, 32'h9, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 6);
        op(32'h30, 32'h0, 4'hF, 4'h0, 32'h9, 1, 1, 1, 0, 6);
        chk_err("pre-range");

        op(32'h0,    32'hCAFE0000, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 2);
        op(32'h1000, 32'h12345678, 4'h0, 4'hF, 32'h0, 1, 1, 1, 1, 4);
        op(32'h0,    32'h0,        4'hF, 4'h0, 32'hCAFE0000, 1, 1, 1, 0, 6);
        op(32'h1000, 32'h0,        4'hF, 4'h0, 32'h0, 1, 1, 1, 1, 6);
        chk_err("out-of-range");

        op(32'h40, 32'h7, 4'hF, 4'hF, 32'h0, 1, 1, 1, 1, 6);
        chk_err("illegal");
        op(32'h40, 32'h0, 4'hF, 4'h0, 32'h7, 1, 1, 1, 0, 6);

        op(32'h50, 32'hA5A55A5A, 4'h0, 4'hF, 32'h0, 1, 1, 1, 0, 2);
        op(32'h50, 32'h0, 4'hF, 4'h0, 32'hA5A55A5A, 1, 1, 0, 0, 0);
        rst2 = 1'b0;
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        repeat (6) @(negedge clk);
        op(32'h50, 32'h0, 4'hF, 4'h0, 32'hA5A55A5A, 1, 1, 1, 0, 6);
        op(32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 1, 1, 1, 0, 6);
        chk_err("final");

        mon_en = 1'b0;
        chk("dut0 pending reads", 32'(q0.size()), 32'h0);
        chk("dut1 pending reads", 32'(q1.size()), 32'h0);
        chk("dut2 pending reads", 32'(q2.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
